// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared constants and reset-pattern helper for the scoreboarded register file
package regfile_scoreboard_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    // Reset pattern: every register holds its own index (register 0 therefore holds 0).
    function automatic logic [63:0] reg_init(input int unsigned idx);
        return 64'(idx);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port with write bypass and operand-ready logic
module regfile_read_port
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     regs_i [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]  busy_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  ready_o
);

    logic zero_idx;
    logic bypass_hit;

    always_comb begin
        zero_idx   = (ZERO_REG != 0) && (addr_i == ADDR_W'(REG_ZERO));
        bypass_hit = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr_i) && !zero_idx;

        // Register 0 is forced rather than trusted from the array when hardwired.
        if (zero_idx) begin
            data_o = '0;
        end else if (bypass_hit) begin
            data_o = wr_data_i;
        end else begin
            data_o = regs_i[addr_i];
        end

        ready_o = zero_idx || bypass_hit || !busy_i[addr_i];
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-read-port register file with per-register busy scoreboard
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rsv_en,
    input  logic [ADDR_W-1:0]            rsv_addr,
    output logic                         rsv_stall,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_ready
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_accept;
    logic              rsv_zero;
    logic              rsv_accept;

    always_comb begin
        wr_accept  = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));
        rsv_zero   = (ZERO_REG != 0) && (rsv_addr == ADDR_W'(REG_ZERO));
        rsv_stall  = rsv_en && busy_q[rsv_addr] && !(wr_en && (wr_addr == rsv_addr)) && !rsv_zero;
        rsv_accept = rsv_en && !rsv_stall && !rsv_zero;

        // Reservation is applied after the write clear so a same-index pair leaves the bit set.
        busy_d = busy_q;
        if (wr_accept) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_accept) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= DATA_W'(reg_init(i));
            end
            busy_q <= '0;
        end else begin
            if (wr_accept) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .addr_i    (rd_addr[k*ADDR_W +: ADDR_W]),
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .data_o    (rd_data[k*DATA_W +: DATA_W]),
            .ready_o   (rd_ready[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [9:0]  rd_addr;
    logic        rsv_stall, nb_rsv_stall;
    logic [63:0] rd_data, nb_rd_data;
    logic [1:0]  rd_ready, nb_rd_ready;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_stall(rsv_stall),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_stall(nb_rsv_stall),
        .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_ready(nb_rd_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        set_rd(5'd7, 5'd31);
        #3;
        check("rst_rd0",    64'(rd_data[31:0]),  64'd7);
        check("rst_rd1",    64'(rd_data[63:32]), 64'd31);
        check("rst_ready",  64'(rd_ready),       64'h3);
        check("rst_stall",  64'(rsv_stall),      64'h0);

        step(); reset = 1'b0;
        #1;
        check("post_rst_rd0", 64'(rd_data[31:0]),  64'd7);
        check("post_rst_rd1", 64'(rd_data[63:32]), 64'd31);

        // write then read, and write to register 0 is dropped
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step(); idle(); set_rd(5'd5, 5'd31);
        #1;
        check("wr5_rd", 64'(rd_data[31:0]), 64'hDEADBEEF);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; set_rd(5'd0, 5'd5);
        #1;
        check("wr0_nobypass", 64'(rd_data[31:0]), 64'h0);
        step(); idle();
        #1;
        check("wr0_rd",     64'(rd_data[31:0]), 64'h0);
        check("wr0_ready",  64'(rd_ready[0]),   64'h1);

        // bypass versus no bypass
        set_rd(5'd9, 5'd5); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
        #1;
        check("byp_rd",      64'(rd_data[31:0]),    64'hA5A5A5A5);
        check("byp_ready",   64'(rd_ready[0]),      64'h1);
        check("nobyp_rd",    64'(nb_rd_data[31:0]), 64'd9);
        step(); idle();
        #1;
        check("nobyp_after", 64'(nb_rd_data[31:0]), 64'hA5A5A5A5);

        // RAW scoreboard on index 12
        set_rd(5'd12, 5'd5); rsv_en = 1'b1; rsv_addr = 5'd12;
        #1;
        check("raw_pre_ready", 64'(rd_ready[0]), 64'h1);
        step(); idle();
        #1;
        check("raw_busy",     64'(rd_ready[0]),    64'h0);
        check("raw_busy_nb",  64'(nb_rd_ready[0]), 64'h0);
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h55;
        #1;
        check("raw_byp_ready", 64'(rd_ready[0]),      64'h1);
        check("raw_byp_data",  64'(rd_data[31:0]),    64'h55);
        check("raw_nb_ready",  64'(nb_rd_ready[0]),   64'h0);
        check("raw_nb_data",   64'(nb_rd_data[31:0]), 64'd12);
        step(); idle();
        #1;
        check("raw_done_ready", 64'(rd_ready[0]),   64'h1);
        check("raw_done_data",  64'(rd_data[31:0]), 64'h55);

        // WAW stall on index 3
        rsv_en = 1'b1; rsv_addr = 5'd3;
        #1;
        check("waw_first_stall", 64'(rsv_stall), 64'h0);
        step();
        #1;
        check("waw_stall", 64'(rsv_stall), 64'h1);
        step(); idle(); set_rd(5'd12, 5'd3);
        #1;
        check("waw_busy_kept", 64'(rd_ready[1]), 64'h0);
        rsv_en = 1'b1; rsv_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
        #1;
        check("waw_wr_nostall", 64'(rsv_stall), 64'h0);
        step(); idle();
        #1;
        check("waw_rsv_wins", 64'(rd_ready[1]),    64'h0);
        check("waw_wr_data",  64'(rd_data[63:32]), 64'h77);

        // reservation of register 0 is ignored
        rsv_en = 1'b1; rsv_addr = 5'd0; set_rd(5'd0, 5'd3);
        #1;
        check("rsv0_stall", 64'(rsv_stall), 64'h0);
        step(); idle();
        #1;
        check("rsv0_ready", 64'(rd_ready[0]), 64'h1);

        // write and reservation on different indices
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h88; rsv_en = 1'b1; rsv_addr = 5'd6;
        step(); idle(); set_rd(5'd6, 5'd3);
        #1;
        check("split_ready", 64'(rd_ready),        64'h2);
        check("split_data",  64'(rd_data[63:32]),  64'h88);

        // asynchronous reset with pending reservations
        rsv_en = 1'b1; rsv_addr = 5'd4;  step();
        rsv_addr = 5'd8;  step();
        rsv_addr = 5'd20; step(); idle(); set_rd(5'd4, 5'd8);
        #1;
        check("pend_ready", 64'(rd_ready), 64'h0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_ready", 64'(rd_ready),        64'h3);
        check("arst_rd4",   64'(rd_data[31:0]),   64'd4);
        check("arst_rd8",   64'(rd_data[63:32]),  64'd8);
        set_rd(5'd20, 5'd3);
        #1;
        check("arst_ready2", 64'(rd_ready),       64'h3);
        check("arst_rd3",    64'(rd_data[63:32]), 64'd3);
        step(); reset = 1'b0;
        set_rd(5'd5, 5'd12);
        #1;
        check("arst_rd5",  64'(rd_data[31:0]),  64'd5);
        check("arst_rd12", 64'(rd_data[63:32]), 64'd12);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-read-port register file for the datapath. It adds a per-register busy scoreboard so the issue stage can detect RAW and WAW hazards. It also provides optional write-to-read bypass. It replaces the fixed 32x32, 2-read-port register file and sits between decode (reads, reservations) and write-back (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_READ, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write-back strobe
wr_addr  input  ADDR_W  write index
wr_data  input  DATA_W  write data
rsv_en  input  1  issue stage reserves a destination register
rsv_addr  input  ADDR_W  index to reserve
rsv_stall  output  1  reservation refused (WAW on busy register)
rd_addr  input  NUM_READ*ADDR_W  packed read indices, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_READ*DATA_W  packed read data
rd_ready  output  NUM_READ  port k operand valid (no pending write)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset state:
  - reg[i] = i, zero-extended or truncated to DATA_W; reg[0] = 0.
  - All busy bits = 0.
  - Outputs are combinational from this state: rd_data[k] = rd_addr[k] (0 for index 0), rd_ready = all 1s, rsv_stall = 0.
- Reset mid-operation: clears every pending reservation immediately and restores the reset pattern, regardless of wr_en/rsv_en.
- Reads: combinational, zero latency, from the array state; all ports are independent.
- Write: at posedge clk with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. With ZERO_REG=1, a write to index 0 is dropped.
- Bypass (BYPASS=1): if wr_en=1 and wr_addr == rd_addr[k] (and the index is nonzero when ZERO_REG=1), then rd_data[k] = wr_data and rd_ready[k] = 1 in the same cycle. With BYPASS=0, the read returns the old value and rd_ready[k] reflects the busy bit until the edge.
- rd_ready[k] = !busy[rd_addr[k]] OR bypass hit. Index 0 is always ready when ZERO_REG=1.
- Reservation:
  - rsv_stall = rsv_en & busy[rsv_addr] & !(wr_en & wr_addr == rsv_addr). It is 0 for index 0 when ZERO_REG=1.
  - An accepted reservation (rsv_en & !rsv_stall) sets busy[rsv_addr] at posedge. Data is unchanged.
  - A reservation to index 0 when ZERO_REG=1 is ignored: no busy bit set, no stall.
- Simultaneous write and reservation, same index: the write updates data, and the busy bit ends set (the new reservation wins). No stall.
- Simultaneous write and reservation, different indices: both take effect.
- Write to a non-busy register is legal: data updates and busy stays 0.
- Arithmetic: no arithmetic. Index compares are full ADDR_W; all addresses are in range by construction (depth = 2**ADDR_W).
- Outputs are purely combinational from state and inputs; there is no registered output latency.

Decomposition:
- Shared package holds:
  - default DATA_W/ADDR_W constants
  - REG_ZERO index constant
  - reset-init function (index to value)
- One sub-module, regfile_read_port, instantiated NUM_READ times. It handles the array read mux, bypass compare and ready logic.
- Storage array and scoreboard stay in the top module.

Test Plan:
1. Reset then read: assert reset; read ports 0/1 at indices 7 and 31 -> rd_data = 7 and 31, rd_ready = 1. Deassert, re-read -> unchanged.
2. Write then read: wr_en, wr_addr=5, wr_data=0xDEADBEEF at edge. Next cycle, read index 5 -> 0xDEADBEEF. Write index 0 with 0x1234 -> read index 0 returns 0.
3. Bypass: wr_en, wr_addr=9, wr_data=0xA5A5A5A5 while rd_addr0=9 -> rd_data0 = 0xA5A5A5A5 and rd_ready0 = 1 in the same cycle. Repeat with BYPASS=0 -> returns 9 until the edge.
4. RAW scoreboard: reserve index 12 -> next cycle rd_ready for index 12 = 0. Write 12 with 0x55 -> ready is 1 that cycle (bypass) and after; data = 0x55.
5. WAW stall: reserve 3, then reserve 3 again with no write -> rsv_stall = 1 and busy unchanged. Same cycle as a write to 3 -> rsv_stall = 0 and busy[3] = 1 after the edge.
6. Async reset mid-operation: reserve 4, 8, 20; assert reset between edges -> rd_ready all 1 and rd_data[4] = 4 immediately, without a clock edge.
